rf_wb_arbiter: RTL and testbench
================================

Name: rf_wb_arbiter

Overview:
Writeback controller for the 32x32 register file's single write port. It arbitrates between the ALU writeback path (A) and the load/long-latency writeback path (M), then drives the register-file write port from a registered output stage. It also keeps a per-register busy scoreboard, so decode can stall on operands whose writeback is still pending.

Parameters:
DATA_W, 32, register data width
ADDR_W, 5, register index width
NREG, 32, number of architectural registers (2**ADDR_W)

Ports:
clk  input  1  clock, rising-edge
rst  input  1  reset, asynchronous, active-high
a_valid  input  1  ALU writeback request
a_reg  input  ADDR_W  ALU destination register
a_data  input  DATA_W  ALU result
a_ready  output  1  ALU request accepted this cycle
m_valid  input  1  memory-path writeback request
m_reg  input  ADDR_W  memory-path destination register
m_data  input  DATA_W  memory-path result
m_ready  output  1  memory request accepted this cycle
iss_valid  input  1  instruction issued with a destination register
iss_reg  input  ADDR_W  destination register to mark busy
chk_reg1  input  ADDR_W  decode source register 1
chk_reg2  input  ADDR_W  decode source register 2
chk_busy1  output  1  chk_reg1 has a pending write
chk_busy2  output  1  chk_reg2 has a pending write
rf_write_reg  output  ADDR_W  to register file writeReg
rf_write_data  output  DATA_W  to register file writeData
rf_write_en  output  1  to register file writeControl
busy_count  output  ADDR_W+1  number of busy registers

Behaviour:
- Reset (async, rst=1): rf_write_en=0, rf_write_reg=0, rf_write_data=0, all busy bits=0, busy_count=0, RR pointer favours A. An in-flight write in the output stage is discarded.
- Grant logic (combinational):
  - Only one request valid: that requester is granted.
  - Both valid: the RR pointer decides; the pointer points to the path that did not win the last conflict.
  - a_ready / m_ready = grant to that path. At most one is high per cycle; neither is high while rst=1.
- Pointer update: changes only on conflict cycles (both valid) and moves to the loser. Single-requester grants leave it unchanged.
- Handshake:
  - A transfer occurs when valid and ready are both high at a clock edge.
  - A non-granted requester must hold valid, reg and data stable until it is granted.
- Output stage:
  - A transfer at edge N sets rf_write_en=1 with the winner's reg/data during cycle N+1. The register file commits at edge N+1.
  - With no transfer, rf_write_en=0 next cycle; reg/data hold their last values.
  - Throughput is one write per cycle. No backpressure from the register file.
- Scoreboard (busy bit per register):
  - At each edge, busy[iss_reg] is set when iss_valid=1.
  - busy[rf_write_reg] is cleared when rf_write_en=1, i.e. at the commit edge.
  - If set and clear target the same register at the same edge, set wins (the newer issue owns it).
  - chk_busyX = busy[chk_regX], combinational. No forwarding: a register reads not-busy from the cycle after the commit edge.
  - Writes to register 0 are passed through like any other register; the scoreboard treats r0 normally.
  - Writebacks to a non-busy register are still written; the clear is a no-op.
- busy_count:
  - Registered popcount of the busy vector, updated at the same edge as the bits.
  - Range 0..NREG. Cannot wrap, because it is derived from the bit vector rather than inc/dec.

Decomposition:
- Shared package: DATA_W/ADDR_W/NREG constants; path-ID encoding (PATH_A=0, PATH_M=1) used by the RR pointer.
- One natural sub-module: rf_scoreboard, which owns the busy vector, the set/clear priority, the check ports and busy_count. Arbiter and output stage stay in the top.

Test Plan:
- Reset mid-write: A transfer (r5, 0xDEAD_BEEF) at edge N, rst asserted during cycle N+1 → rf_write_en drops to 0 immediately, r5 busy bit and busy_count both 0 after reset.
- Single path: a_valid (r3, 0x11) with m_valid=0 → a_ready=1 same cycle; next cycle rf_write_en=1, reg=3, data=0x11.
- Conflict round-robin: A (r1, 0xA1) and M (r2, 0xB2) held valid for 3 cycles → A is granted first, then M, then A; pointer alternates.
- Scoreboard lifecycle: iss_valid r7 at edge 0 → chk_busy1 (chk_reg1=7) = 1 and busy_count=1. M writeback (r7) transferred at edge 4 and committed at edge 5 → chk_busy1=0 from cycle 5, busy_count=0.
- Set/clear collision: r9 commits at edge N while iss_valid r9 occurs at the same edge → busy[9] remains 1 and busy_count is unchanged.
- Full scoreboard: issue r0..r31 on 32 consecutive cycles → busy_count=32 and every chk_busy=1. Drain all 32 via A → busy_count returns to 0.

Source files
------------

// File: rtl/rf_wb_arbiter_pkg.sv
// Shared constants, path encoding and helpers for the register-file writeback block.
package rf_wb_arbiter_pkg;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;
    localparam int NREG   = 32;

    // Writeback path identifiers, used by the round-robin pointer
    typedef enum logic {
        PATH_A = 1'b0,
        PATH_M = 1'b1
    } path_e;

    // Number of set bits in a busy vector (0..NREG)
    function automatic logic [ADDR_W:0] popCount(input logic [NREG-1:0] v);
        logic [ADDR_W:0] cnt;
        cnt = '0;
        for (int i = 0; i < NREG; i++) begin
            cnt = cnt + {{ADDR_W{1'b0}}, v[i]};
        end
        return cnt;
    endfunction

endpackage

// File: rtl/rf_wb_if.sv
// Writeback, issue, operand-check and register-file write bundle.
interface rf_wb_if;
    import rf_wb_arbiter_pkg::*;

    logic              a_valid;
    logic [ADDR_W-1:0] a_reg;
    logic [DATA_W-1:0] a_data;
    logic              a_ready;

    logic              m_valid;
    logic [ADDR_W-1:0] m_reg;
    logic [DATA_W-1:0] m_data;
    logic              m_ready;

    logic              iss_valid;
    logic [ADDR_W-1:0] iss_reg;

    logic [ADDR_W-1:0] chk_reg1;
    logic [ADDR_W-1:0] chk_reg2;
    logic              chk_busy1;
    logic              chk_busy2;

    logic [ADDR_W-1:0] rf_write_reg;
    logic [DATA_W-1:0] rf_write_data;
    logic              rf_write_en;
    logic [ADDR_W:0]   busy_count;

    // Pipeline side: issues requests, checks operands, observes the write port
    modport master (
        output a_valid, a_reg, a_data, input a_ready,
        output m_valid, m_reg, m_data, input m_ready,
        output iss_valid, iss_reg,
        output chk_reg1, chk_reg2, input chk_busy1, chk_busy2,
        input  rf_write_reg, rf_write_data, rf_write_en, busy_count
    );

    // Writeback controller side
    modport slave (
        input  a_valid, a_reg, a_data, output a_ready,
        input  m_valid, m_reg, m_data, output m_ready,
        input  iss_valid, iss_reg,
        input  chk_reg1, chk_reg2, output chk_busy1, chk_busy2,
        output rf_write_reg, rf_write_data, rf_write_en, busy_count
    );

endinterface

// File: rtl/rf_wb_arbiter_scoreboard.sv
// Per-register busy bits: set on issue, cleared on commit, newer issue wins a tie.
module rf_scoreboard
    import rf_wb_arbiter_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              setEn,
    input  logic [ADDR_W-1:0] setReg,
    input  logic              clrEn,
    input  logic [ADDR_W-1:0] clrReg,
    input  logic [ADDR_W-1:0] chkReg1,
    input  logic [ADDR_W-1:0] chkReg2,
    output logic              chkBusy1,
    output logic              chkBusy2,
    output logic [ADDR_W:0]   busyCount
);

    logic [NREG-1:0] busy;
    logic [NREG-1:0] busyNext;

    // Next busy vector: apply the commit clear first so a same-edge issue overrides it
    always_comb begin
        busyNext = busy;
        if (clrEn) busyNext[clrReg] = 1'b0;
        if (setEn) busyNext[setReg] = 1'b1;
    end

    // Busy bits and their population count move together on the same edge
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy      <= '0;
            busyCount <= '0;
        end else begin
            busy      <= busyNext;
            busyCount <= popCount(busyNext);
        end
    end

    // Operand checks see the registered state only; no forwarding of this edge's commit
    assign chkBusy1 = busy[chkReg1];
    assign chkBusy2 = busy[chkReg2];

endmodule

// File: rtl/rf_wb_arbiter.sv
// Writeback arbiter for the register file's single write port, with busy scoreboard.
module rf_wb_arbiter
    import rf_wb_arbiter_pkg::*;
(
    input  logic   clk,
    input  logic   rst,
    rf_wb_if.slave bus
);

    path_e             rrPtr;
    logic              conflict;
    logic              aGrant;
    logic              mGrant;
    logic              vld_p1;
    logic [ADDR_W-1:0] wrReg_p1;
    logic [DATA_W-1:0] wrData_p1;

    // Grant: a lone requester wins; on a conflict the pointer picks; nothing during reset
    always_comb begin
        conflict = bus.a_valid && bus.m_valid;
        aGrant   = 1'b0;
        mGrant   = 1'b0;
        if (!rst) begin
            if (conflict) begin
                aGrant = (rrPtr == PATH_A);
                mGrant = (rrPtr == PATH_M);
            end else begin
                aGrant = bus.a_valid;
                mGrant = bus.m_valid;
            end
        end
    end

    assign bus.a_ready = aGrant;
    assign bus.m_ready = mGrant;

    // Round-robin pointer moves to the loser, and only on conflict cycles
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rrPtr <= PATH_A;
        end else if (conflict) begin
            rrPtr <= (rrPtr == PATH_A) ? PATH_M : PATH_A;
        end
    end

    // ---- stage p1: registered write port; reg/data hold when idle ----
    // Output stage captures the winner; reset discards any in-flight write
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_p1    <= 1'b0;
            wrReg_p1  <= '0;
            wrData_p1 <= '0;
        end else begin
            vld_p1 <= aGrant || mGrant;
            if (aGrant) begin
                wrReg_p1  <= bus.a_reg;
                wrData_p1 <= bus.a_data;
            end else if (mGrant) begin
                wrReg_p1  <= bus.m_reg;
                wrData_p1 <= bus.m_data;
            end
        end
    end

    assign bus.rf_write_en   = vld_p1;
    assign bus.rf_write_reg  = wrReg_p1;
    assign bus.rf_write_data = wrData_p1;

    rf_scoreboard uScoreboard (
        .clk       (clk),
        .rst       (rst),
        .setEn     (bus.iss_valid),
        .setReg    (bus.iss_reg),
        .clrEn     (vld_p1),
        .clrReg    (wrReg_p1),
        .chkReg1   (bus.chk_reg1),
        .chkReg2   (bus.chk_reg2),
        .chkBusy1  (bus.chk_busy1),
        .chkBusy2  (bus.chk_busy2),
        .busyCount (bus.busy_count)
    );

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Directed scoreboard bench for rf_wb_arbiter.
module tb_rf_wb_arbiter;
    import rf_wb_arbiter_pkg::*;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    logic [ADDR_W+DATA_W-1:0] expQ[$];

    rf_wb_if ifc ();

    rf_wb_arbiter dut (
        .clk (clk),
        .rst (rst),
        .bus (ifc.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Check grants against the hand-computed winner and queue the write it produces
    task automatic expectGrant(input string name, input logic expA, input logic expM);
        check({name, "_a_ready"}, 64'(ifc.a_ready), 64'(expA));
        check({name, "_m_ready"}, 64'(ifc.m_ready), 64'(expM));
        if (expA) expQ.push_back({ifc.a_reg, ifc.a_data});
        else if (expM) expQ.push_back({ifc.m_reg, ifc.m_data});
    endtask

    // Monitor: every presented write must match the oldest queued expectation
    always @(negedge clk) begin
        logic [ADDR_W+DATA_W-1:0] exp;
        if (!rst && ifc.rf_write_en) begin
            checks++;
            if (expQ.size() == 0) begin
                errors++;
                $display("FAIL wr_unexpected actual reg=%0d data=%0h expected none at %0t",
                         ifc.rf_write_reg, ifc.rf_write_data, $time);
            end else begin
                exp = expQ.pop_front();
                if ({ifc.rf_write_reg, ifc.rf_write_data} !== exp) begin
                    errors++;
                    $display("FAIL wr_port actual reg=%0d data=%0h expected reg=%0d data=%0h at %0t",
                             ifc.rf_write_reg, ifc.rf_write_data,
                             exp[ADDR_W+DATA_W-1:DATA_W], exp[DATA_W-1:0], $time);
                end
            end
        end
    end

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b1;
        ifc.a_valid = 1'b1; ifc.a_reg = 5'd4; ifc.a_data = 32'h1;
        ifc.m_valid = 1'b0; ifc.m_reg = '0;   ifc.m_data = '0;
        ifc.iss_valid = 1'b0; ifc.iss_reg = '0;
        ifc.chk_reg1 = '0; ifc.chk_reg2 = '0;

        // Reset state; no grant while rst is high even with a request pending
        step();
        step();
        check("rst_a_ready", 64'(ifc.a_ready), 64'd0);
        check("rst_wr_en",   64'(ifc.rf_write_en), 64'd0);
        check("rst_wr_reg",  64'(ifc.rf_write_reg), 64'd0);
        check("rst_wr_data", 64'(ifc.rf_write_data), 64'd0);
        check("rst_count",   64'(ifc.busy_count), 64'd0);
        ifc.a_valid = 1'b0;
        rst = 1'b0;
        step();

        // Reset mid-write: transfer r5 then assert rst during the write cycle
        ifc.a_valid = 1'b1; ifc.a_reg = 5'd5; ifc.a_data = 32'hDEAD_BEEF;
        ifc.iss_valid = 1'b1; ifc.iss_reg = 5'd5;
        ifc.chk_reg1 = 5'd5;
        #1;
        check("midrst_a_ready", 64'(ifc.a_ready), 64'd1);
        step();
        rst = 1'b1;
        ifc.a_valid = 1'b0; ifc.iss_valid = 1'b0;
        #1;
        check("midrst_wr_en", 64'(ifc.rf_write_en), 64'd0);
        check("midrst_busy5", 64'(ifc.chk_busy1), 64'd0);
        check("midrst_count", 64'(ifc.busy_count), 64'd0);
        step();
        rst = 1'b0;
        step();

        // Single path A
        ifc.a_valid = 1'b1; ifc.a_reg = 5'd3; ifc.a_data = 32'h11;
        #1;
        expectGrant("single_a", 1'b1, 1'b0);
        step();
        ifc.a_valid = 1'b0;
        step();

        // Conflict: A first (pointer at reset), then M, then A
        ifc.a_valid = 1'b1; ifc.a_reg = 5'd1; ifc.a_data = 32'hA1;
        ifc.m_valid = 1'b1; ifc.m_reg = 5'd2; ifc.m_data = 32'hB2;
        #1;
        expectGrant("rr1", 1'b1, 1'b0);
        step();
        expectGrant("rr2", 1'b0, 1'b1);
        step();
        expectGrant("rr3", 1'b1, 1'b0);
        step();
        ifc.a_valid = 1'b0; ifc.m_valid = 1'b0;
        step();

        // Scoreboard lifecycle on r7, cleared by an M writeback
        ifc.chk_reg1 = 5'd7;
        ifc.iss_valid = 1'b1; ifc.iss_reg = 5'd7;
        step();
        ifc.iss_valid = 1'b0;
        check("life_busy_set",  64'(ifc.chk_busy1), 64'd1);
        check("life_count_set", 64'(ifc.busy_count), 64'd1);
        step();
        step();
        ifc.m_valid = 1'b1; ifc.m_reg = 5'd7; ifc.m_data = 32'h77;
        #1;
        expectGrant("life_m", 1'b0, 1'b1);
        step();
        ifc.m_valid = 1'b0;
        check("life_busy_inflight", 64'(ifc.chk_busy1), 64'd1);
        step();
        check("life_busy_clr",  64'(ifc.chk_busy1), 64'd0);
        check("life_count_clr", 64'(ifc.busy_count), 64'd0);

        // Set/clear collision on r9: the same-edge issue keeps it busy
        ifc.chk_reg1 = 5'd9;
        ifc.iss_valid = 1'b1; ifc.iss_reg = 5'd9;
        step();
        ifc.iss_valid = 1'b0;
        ifc.a_valid = 1'b1; ifc.a_reg = 5'd9; ifc.a_data = 32'h99;
        #1;
        expectGrant("coll_a", 1'b1, 1'b0);
        step();
        ifc.a_valid = 1'b0;
        ifc.iss_valid = 1'b1; ifc.iss_reg = 5'd9;
        step();
        ifc.iss_valid = 1'b0;
        check("coll_busy9", 64'(ifc.chk_busy1), 64'd1);
        check("coll_count", 64'(ifc.busy_count), 64'd1);
        ifc.a_valid = 1'b1; ifc.a_reg = 5'd9; ifc.a_data = 32'h9A;
        #1;
        expectGrant("coll_a2", 1'b1, 1'b0);
        step();
        ifc.a_valid = 1'b0;
        step();
        check("coll_count_clr", 64'(ifc.busy_count), 64'd0);

        // Full scoreboard: issue r0..r31 then drain all through A
        for (int i = 0; i < NREG; i++) begin
            ifc.iss_valid = 1'b1; ifc.iss_reg = ADDR_W'(i);
            step();
        end
        ifc.iss_valid = 1'b0;
        check("full_count", 64'(ifc.busy_count), 64'd32);
        for (int i = 0; i < NREG; i++) begin
            ifc.chk_reg1 = ADDR_W'(i);
            ifc.chk_reg2 = ADDR_W'(NREG - 1 - i);
            #1;
            check("full_busy1", 64'(ifc.chk_busy1), 64'd1);
            check("full_busy2", 64'(ifc.chk_busy2), 64'd1);
        end
        for (int i = 0; i < NREG; i++) begin
            ifc.a_valid = 1'b1; ifc.a_reg = ADDR_W'(i); ifc.a_data = 32'h1000 + 32'(i);
            #1;
            expectGrant("drain", 1'b1, 1'b0);
            step();
        end
        ifc.a_valid = 1'b0;
        step();
        check("drain_count", 64'(ifc.busy_count), 64'd0);
        ifc.chk_reg1 = 5'd31;
        #1;
        check("drain_busy31", 64'(ifc.chk_busy1), 64'd0);

        // Every queued write must have been presented
        step();
        step();
        check("queue_empty", 64'(expQ.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
